// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a valid/ready request and result handshake.
// Optional macro SEQ_DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iteration.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy,
    output logic [2:0]   o_dbg_state
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready,
    // a result transfers on a rising edge with out_valid && out_ready; once raised,
    // out_valid and result hold until that transfer completes.

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_dvs;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_quo;
    logic           r_qneg;
    logic           r_rneg;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic [N:0]     w_part;
    logic [N:0]     w_trial;
    logic           w_signed;
    logic           w_early;

    // op[0]=0 selects the signed forms, op[1]=1 selects the remainder
    assign w_signed = ~r_op[0];
    assign w_part   = {r_rem, r_quo[N-1]};
    assign w_trial  = w_part - {1'b0, r_dvs};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic         w_in_bzero;
    logic         w_in_ovf;
    logic [N-1:0] w_early_res;

    assign w_in_bzero  = (b == '0);
    assign w_in_ovf    = ~op[0] && (a == MIN_NEG) && (b == '1);
    assign w_early     = w_in_bzero || w_in_ovf;
    assign w_early_res = op[1] ? (w_in_bzero ? a : '0)
                               : (w_in_bzero ? '1 : MIN_NEG);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = w_early ? S_DONE : S_PREP;
                end
            end
            S_PREP: w_next = S_ITER;
            S_ITER: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:  w_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        if (w_early) begin
                            r_result <= w_early_res;
                        end
`endif
                    end
                end
                S_PREP: begin
                    r_quo  <= (w_signed && r_a[N-1]) ? -r_a : r_a;
                    r_dvs  <= (w_signed && r_b[N-1]) ? -r_b : r_b;
                    r_rem  <= '0;
                    r_qneg <= w_signed && (r_a[N-1] ^ r_b[N-1]);
                    r_rneg <= w_signed && r_a[N-1];
                    r_cnt  <= CW'(N - 1);
                end
                S_ITER: begin
                    // A negative trial keeps the shifted partial remainder (restore)
                    r_rem <= w_trial[N] ? w_part[N-1:0] : w_trial[N-1:0];
                    r_quo <= {r_quo[N-2:0], ~w_trial[N]};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (r_b == '0) begin
                        r_result <= r_op[1] ? r_a : '1;
                    end else if (r_op[1]) begin
                        r_result <= r_rneg ? -r_rem : r_rem;
                    end else begin
                        r_result <= r_qneg ? -r_quo : r_quo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: driver pushes hand-computed results into a queue, a monitor pops and compares.
module tb_seq_divider;

    localparam int N = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int NLAT = N + 3;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = N + 3;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         busy;
    logic [2:0]   dbg_state;

    logic [N-1:0] exp_q[$];
    int           lat_q[$];
    longint       acc_q[$];
    int           total = 0;
    int           bad = 0;
    logic         seen = 1'b0;

    seq_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy),
        .o_dbg_state(dbg_state)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // driver
    task automatic send(input logic [1:0] t_op, input logic [N-1:0] t_a, input logic [N-1:0] t_b,
                        input logic [N-1:0] t_exp, input int t_lat);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        op = t_op;
        a = t_a;
        b = t_b;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(t_exp);
            lat_q.push_back(t_lat);
            acc_q.push_back(longint'($time));
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((exp_q.size() != 0 || !in_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", N'(waited >= 200), '0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [N-1:0] e;
                int           l;
                longint       t;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                t = acc_q.pop_front();
                check("result", result, e);
                check("latency", N'((longint'($time) + 5 - t) / 10), N'(l));
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", N'(in_ready), 1);
        check("rst_out_valid", N'(out_valid), 0);
        check("rst_busy", N'(busy), 0);
        check("rst_result", result, '0);
        @(negedge clk);
        rst = 1'b0;

        send(OP_DIVU, 100, 7, 14, NLAT);
        @(negedge clk);
        check("busy_mid", N'(busy), 1);
        check("in_ready_mid", N'(in_ready), 0);
        wait_drain();
        send(OP_REMU, 100, 7, 2, NLAT);
        send(OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, NLAT);
        send(OP_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, NLAT);
        send(OP_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NLAT);
        send(OP_REM, 7, 32'hFFFF_FFFE, 1, NLAT);
        send(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 3, NLAT);
        send(OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, NLAT);
        send(OP_REMU, 5, 10, 5, NLAT);
        send(OP_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, NLAT);
        send(OP_DIVU, 0, 5, 0, NLAT);
        send(OP_DIV, 32'h1234_5678, 0, 32'hFFFF_FFFF, SLAT);
        send(OP_REM, 32'h1234_5678, 0, 32'h1234_5678, SLAT);
        send(OP_DIVU, 32'h1234_5678, 0, 32'hFFFF_FFFF, SLAT);
        send(OP_REMU, 32'h1234_5678, 0, 32'h1234_5678, SLAT);
        send(OP_DIV, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF, SLAT);
        send(OP_REM, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, SLAT);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SLAT);
        send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SLAT);
        send(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, NLAT);
        wait_drain();

        // result stall with a competing request held on the inputs
        out_ready = 1'b0;
        send(OP_DIVU, 1000, 10, 100, NLAT);
        begin
            int waited = 0;
            while (!out_valid && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            check("stall_wait", N'(out_valid), 1);
        end
        in_valid = 1'b1;
        op = OP_DIVU;
        a = 55;
        b = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_result", result, 100);
            check("stall_valid", N'(out_valid), 1);
            check("stall_in_ready", N'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", N'(in_ready), 1);
        check("post_hs_valid", N'(out_valid), 0);
        in_valid = 1'b0;
        wait_drain();

        // abandon an operation partway through iteration
        send(OP_DIVU, 32'h0001_0000, 3, 32'h0000_5555, NLAT);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", N'(out_valid), 0);
        check("mid_rst_in_ready", N'(in_ready), 1);
        check("mid_rst_busy", N'(busy), 0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(OP_DIVU, 9, 3, 3, NLAT);
        wait_drain();

        repeat (3) @(negedge clk);
        check("queue_empty", N'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
